mem_stage: RTL and testbench
============================

// Module: mem_stage
// PURPOSE
//  MEM stage of the 5-stage MIPS pipeline. Consumes the EX/MEM latch outputs and performs
//  LW/SW on a word-addressed data memory with configurable wait states. Owns the MEM/WB
//  pipeline register and drives the WB stage. Raises stall_out to freeze the upstream
//  PC, IF/ID, ID/EX and EX/MEM registers while a multi-cycle access is in progress.
// PARAMETERS
//  MEM_DEPTH_WORDS  256  data memory depth in 32-bit words (power of 2)
//  WAIT_STATES      0    extra cycles per memory access (0..15); an access takes 1+WAIT_STATES cycles
// PORTS
//  clk                 in   1   pipeline clock, single domain
//  reset               in   1   synchronous, active-high
//  alu_result_in       in   32  effective address for LW/SW, or ALU result to pass through
//  read_data_2_in      in   32  store data (rt)
//  write_register_in   in   5   WB destination register
//  reg_write_in        in   1   WB register write enable
//  mem_read_in         in   1   LW access request
//  mem_write_in        in   1   SW access request
//  mem_to_reg_in       in   1   WB source select (memory vs ALU)
//  read_data_out       out  32  MEM/WB: loaded word
//  alu_result_out      out  32  MEM/WB: ALU result passed through
//  write_register_out  out  5   MEM/WB: destination register
//  reg_write_out       out  1   MEM/WB: register write enable
//  mem_to_reg_out      out  1   MEM/WB: WB source select
//  stall_out           out  1   combinational; 1 = upstream stages must hold
//  align_err_out       out  1   MEM/WB: 1-cycle pulse, misaligned access suppressed
// BEHAVIOUR
//  Reset: all MEM/WB outputs 0; reg_write_out=`CTRL_REG_WRITE_DIS; mem_to_reg_out=`CTRL_MEM_TO_REG_ALU;
//   FSM=IDLE, wait counter=0, stall_out=0. Memory contents are NOT cleared (zero-initialised for simulation only).
//  Word index = alu_result_in[2+log2(MEM_DEPTH_WORDS)-1:2]; upper address bits are ignored (address wraps modulo depth).
//  Non-memory instruction (mem_read_in=mem_write_in=0): 1 cycle; inputs are registered into MEM/WB on the next edge.
//  FSM states: IDLE, BUSY. Access = (mem_read_in|mem_write_in) and aligned.
//   IDLE, access, WAIT_STATES=0 : complete this cycle; stall_out=0.
//   IDLE, access, WAIT_STATES>0 : stall_out=1; -> BUSY, cnt<=1.
//   BUSY, cnt<WAIT_STATES       : stall_out=1; cnt<=cnt+1.
//   BUSY, cnt==WAIT_STATES      : stall_out=0; complete; -> IDLE, cnt<=0.
//  Complete (clock edge): SW writes read_data_2_in to mem[idx]; LW registers mem[idx] (async array read)
//   into read_data_out; all pass-through fields are registered into MEM/WB.
//  While stall_out=1: no memory write; MEM/WB receives a bubble (reg_write_out=0, align_err_out=0,
//   other fields don't-care). Upstream holds its inputs stable until stall_out=0.
//  Back-to-back accesses: the next access starts in the cycle after completion; no idle gap is inserted.
//  Misaligned (alu_result_in[1:0]!=0 with read or write): no wait states; no memory write;
//   MEM/WB gets reg_write_out=0, read_data_out=0, align_err_out=1 for one cycle.
//  mem_read_in & mem_write_in both 1: illegal; treated as SW (write performed), read_data_out=0,
//   reg_write_out forced to 0.
//  Load-after-store to the same word in consecutive instructions: LW returns the newly stored data
//   (the write commits at the SW completion edge, before the LW read).
//  Reset mid-access: pending write discarded; FSM->IDLE, stall_out drops in the same cycle reset is sampled.
// STRUCTURE
//  mips_pkg.vh: `DATA_WIDTH, `REG_ADDR_WIDTH, `CTRL_REG_WRITE_DIS, `CTRL_MEM_TO_REG_ALU, plus new
//   `MEM_ST_IDLE/`MEM_ST_BUSY encodings and `MEM_WAIT_CNT_WIDTH (4).
//  Sub-module data_memory: word array, async read, sync write on we; no reset.
//  mem_stage contains the FSM, wait counter, alignment check and MEM/WB register.
// TESTING
//  WAIT_STATES=0: SW 0xDEADBEEF @0x10, then LW @0x10 -> read_data_out=0xDEADBEEF one cycle later, stall_out never 1.
//  WAIT_STATES=3: LW @0x20 -> stall_out=1 for 3 cycles, reg_write_out=0 during the stall, data valid on 4th edge.
//  SW @0x6 (misaligned) -> align_err_out=1 for one cycle, mem[1] unchanged, reg_write_out=0, no stall.
//  MEM_DEPTH_WORDS=256: SW 0x11 @0x400 then LW @0x0 -> 0x11 (address wrap).
//  WAIT_STATES=2: assert reset in the 2nd stalled cycle of an SW -> stall_out=0, outputs reset, target word unchanged.
//  ADD (reg_write=1, mem ops 0, alu=0x5, rd=7) -> next cycle alu_result_out=5, write_register_out=7, reg_write_out=1.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared widths, control encodings, FSM states and the MEM/WB record
// used by the MEM stage of the 5-stage MIPS pipeline.
package mem_stage_pkg;

    localparam int DATA_WIDTH         = 32;
    localparam int REG_ADDR_WIDTH     = 5;
    localparam int MEM_WAIT_CNT_WIDTH = 4;

    localparam logic CTRL_REG_WRITE_DIS  = 1'b0;
    localparam logic CTRL_MEM_TO_REG_ALU = 1'b0;

    localparam logic [0:0] MEM_ST_IDLE = 1'b0;
    localparam logic [0:0] MEM_ST_BUSY = 1'b1;

    typedef struct packed {
        logic [DATA_WIDTH-1:0]     read_data;
        logic [DATA_WIDTH-1:0]     alu_result;
        logic [REG_ADDR_WIDTH-1:0] write_register;
        logic                      reg_write;
        logic                      mem_to_reg;
        logic                      align_err;
    } mem_wb_t;

    function automatic mem_wb_t mem_wb_reset();
        mem_wb_t r;
        r            = '0;
        r.reg_write  = CTRL_REG_WRITE_DIS;
        r.mem_to_reg = CTRL_MEM_TO_REG_ALU;
        return r;
    endfunction

endpackage

// File: rtl/mem_stage_data_memory.sv
// mem_stage_data_memory: word-addressed data array with asynchronous read and
// synchronous write; contents are deliberately not reset.
module mem_stage_data_memory
    import mem_stage_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [AW-1:0]         addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    assign rdata = mem[addr];

    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
    end

endmodule

// File: rtl/mem_stage.sv
// mem_stage: MIPS MEM stage -- LW/SW with configurable wait states, alignment check,
// upstream stall generation and the MEM/WB pipeline register.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int MEM_DEPTH_WORDS = 256,
    parameter int WAIT_STATES     = 0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [DATA_WIDTH-1:0]     alu_result_in,
    input  logic [DATA_WIDTH-1:0]     read_data_2_in,
    input  logic [REG_ADDR_WIDTH-1:0] write_register_in,
    input  logic                      reg_write_in,
    input  logic                      mem_read_in,
    input  logic                      mem_write_in,
    input  logic                      mem_to_reg_in,
    output logic [DATA_WIDTH-1:0]     read_data_out,
    output logic [DATA_WIDTH-1:0]     alu_result_out,
    output logic [REG_ADDR_WIDTH-1:0] write_register_out,
    output logic                      reg_write_out,
    output logic                      mem_to_reg_out,
    output logic                      stall_out,
    output logic                      align_err_out
);

    localparam int AW = $clog2(MEM_DEPTH_WORDS);
    localparam logic [MEM_WAIT_CNT_WIDTH-1:0] WS = MEM_WAIT_CNT_WIDTH'(WAIT_STATES);

    logic [0:0]                    state_q, state_d;
    logic [MEM_WAIT_CNT_WIDTH-1:0] cnt_q, cnt_d;
    mem_wb_t                       mem_wb_q, mem_wb_d;
    logic                          mem_op, misaligned, access, busy, done, stall, illegal, we;
    logic [DATA_WIDTH-1:0]         mem_rdata;

    mem_stage_data_memory #(.DEPTH(MEM_DEPTH_WORDS), .AW(AW)) u_dmem (
        .clk   (clk),
        .we    (we),
        .addr  (alu_result_in[AW+1:2]),
        .wdata (read_data_2_in),
        .rdata (mem_rdata)
    );

    always_comb begin
        mem_op     = mem_read_in | mem_write_in;
        misaligned = mem_op & (alu_result_in[1:0] != 2'b00);
        access     = mem_op & ~misaligned;
        busy       = state_q == MEM_ST_BUSY;
        done       = (WAIT_STATES == 0) | (busy & (cnt_q == WS));
        // Gating with reset lets the stall drop in the very cycle reset is sampled.
        stall      = ~reset & access & ~done;
        illegal    = mem_read_in & mem_write_in;
        we         = ~reset & access & ~stall & mem_write_in;
        state_d    = stall ? MEM_ST_BUSY : MEM_ST_IDLE;
        cnt_d      = stall ? (busy ? cnt_q + 1'b1 : MEM_WAIT_CNT_WIDTH'(1)) : '0;
        mem_wb_d.read_data      = (access & ~stall & mem_read_in & ~mem_write_in) ? mem_rdata : '0;
        mem_wb_d.alu_result     = alu_result_in;
        mem_wb_d.write_register = write_register_in;
        mem_wb_d.reg_write      = reg_write_in & ~stall & ~misaligned & ~illegal;
        mem_wb_d.mem_to_reg     = mem_to_reg_in;
        mem_wb_d.align_err      = misaligned;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= MEM_ST_IDLE;
            cnt_q    <= '0;
            mem_wb_q <= mem_wb_reset();
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mem_wb_q <= mem_wb_d;
        end
    end

    assign read_data_out      = mem_wb_q.read_data;
    assign alu_result_out     = mem_wb_q.alu_result;
    assign write_register_out = mem_wb_q.write_register;
    assign reg_write_out      = mem_wb_q.reg_write;
    assign mem_to_reg_out     = mem_wb_q.mem_to_reg;
    assign align_err_out      = mem_wb_q.align_err;
    assign stall_out          = stall;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: table-driven scoreboard bench for mem_stage with zero and three wait states.
module tb_mem_stage;

    typedef struct packed {
        logic [31:0] alu;
        logic [31:0] wd;
        logic [4:0]  rd;
        logic        rw;
        logic        mr;
        logic        mw;
        logic        m2r;
    } in_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic [31:0] alu;
        logic [4:0]  wr;
        logic        rw;
        logic        m2r;
        logic        aerr;
    } out_t;

    typedef struct {
        in_t  i;
        out_t o;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    in_t  i0, i3;
    out_t y0, y3;
    logic stall0, stall3;
    logic [31:0] rd0, alu0, rd3, alu3;
    logic [4:0]  wr0, wr3;
    logic        rw0, m2r0, ae0, rw3, m2r3, ae3;

    int   checks   = 0;
    int   failures = 0;
    out_t sb[$];
    vec_t v[13];

    always #5 clk = ~clk;

    mem_stage #(.MEM_DEPTH_WORDS(256), .WAIT_STATES(0)) u0 (
        .clk(clk), .reset(reset),
        .alu_result_in(i0.alu), .read_data_2_in(i0.wd), .write_register_in(i0.rd),
        .reg_write_in(i0.rw), .mem_read_in(i0.mr), .mem_write_in(i0.mw), .mem_to_reg_in(i0.m2r),
        .read_data_out(rd0), .alu_result_out(alu0), .write_register_out(wr0),
        .reg_write_out(rw0), .mem_to_reg_out(m2r0), .stall_out(stall0), .align_err_out(ae0)
    );

    mem_stage #(.MEM_DEPTH_WORDS(256), .WAIT_STATES(3)) u3 (
        .clk(clk), .reset(reset),
        .alu_result_in(i3.alu), .read_data_2_in(i3.wd), .write_register_in(i3.rd),
        .reg_write_in(i3.rw), .mem_read_in(i3.mr), .mem_write_in(i3.mw), .mem_to_reg_in(i3.m2r),
        .read_data_out(rd3), .alu_result_out(alu3), .write_register_out(wr3),
        .reg_write_out(rw3), .mem_to_reg_out(m2r3), .stall_out(stall3), .align_err_out(ae3)
    );

    assign y0 = {rd0, alu0, wr0, rw0, m2r0, ae0};
    assign y3 = {rd3, alu3, wr3, rw3, m2r3, ae3};

    // f = {reg_write, mem_read, mem_write, mem_to_reg}
    function automatic in_t mk(input logic [31:0] alu, input logic [31:0] wd,
                               input logic [4:0] rd, input logic [3:0] f);
        return {alu, wd, rd, f};
    endfunction

    // f = {reg_write, mem_to_reg, align_err}
    function automatic out_t mko(input logic [31:0] rdata, input logic [31:0] alu,
                                 input logic [4:0] wr, input logic [2:0] f);
        return {rdata, alu, wr, f};
    endfunction

    task automatic chk_out(input string nm, input out_t got, input out_t exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got rdata=%h alu=%h wr=%0d rw=%b m2r=%b aerr=%b, expected rdata=%h alu=%h wr=%0d rw=%b m2r=%b aerr=%b",
                     nm, got.rdata, got.alu, got.wr, got.rw, got.m2r, got.aerr,
                     exp.rdata, exp.alu, exp.wr, exp.rw, exp.m2r, exp.aerr);
        end
    endtask

    task automatic chk_val(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h, expected %h", nm, got, exp);
        end
    endtask

    task automatic pop_cmp(input string nm, input out_t got);
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s: scoreboard empty, got rdata=%h", nm, got.rdata);
        end else begin
            chk_out(nm, got, sb.pop_front());
        end
    endtask

    task automatic run3(input string nm, input in_t x, input out_t e, input int exp_stalls);
        int n = 0;
        i3 = x;
        sb.push_back(e);
        #1;
        while (stall3 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
            chk_val({nm, " bubble"}, {31'b0, rw3}, 32'd0);
        end
        chk_val({nm, " stalls"}, n, exp_stalls);
        @(posedge clk);
        #1;
        pop_cmp(nm, y3);
    endtask

    initial begin
        v[0]  = '{mk(32'h5,     32'h0,        5'd7,  4'b1000), mko(32'h0,        32'h5,   5'd7,  3'b100)};
        v[1]  = '{mk(32'h10,    32'hDEADBEEF, 5'd0,  4'b0010), mko(32'h0,        32'h10,  5'd0,  3'b000)};
        v[2]  = '{mk(32'h10,    32'h0,        5'd8,  4'b1101), mko(32'hDEADBEEF, 32'h10,  5'd8,  3'b110)};
        v[3]  = '{mk(32'h4,     32'h12345678, 5'd0,  4'b0010), mko(32'h0,        32'h4,   5'd0,  3'b000)};
        v[4]  = '{mk(32'h6,     32'hAAAA,     5'd0,  4'b0010), mko(32'h0,        32'h6,   5'd0,  3'b001)};
        v[5]  = '{mk(32'h4,     32'h0,        5'd9,  4'b1101), mko(32'h12345678, 32'h4,   5'd9,  3'b110)};
        v[6]  = '{mk(32'h5,     32'h0,        5'd10, 4'b1101), mko(32'h0,        32'h5,   5'd10, 3'b011)};
        v[7]  = '{mk(32'h400,   32'h11,       5'd0,  4'b0010), mko(32'h0,        32'h400, 5'd0,  3'b000)};
        v[8]  = '{mk(32'h0,     32'h0,        5'd11, 4'b1101), mko(32'h11,       32'h0,   5'd11, 3'b110)};
        v[9]  = '{mk(32'h8,     32'h77,       5'd12, 4'b1111), mko(32'h0,        32'h8,   5'd12, 3'b010)};
        v[10] = '{mk(32'h8,     32'h0,        5'd13, 4'b1101), mko(32'h77,       32'h8,   5'd13, 3'b110)};
        v[11] = '{mk(32'h3FC,   32'hCAFE,     5'd0,  4'b0010), mko(32'h0,        32'h3FC, 5'd0,  3'b000)};
        v[12] = '{mk(32'hFFC,   32'h0,        5'd14, 4'b1101), mko(32'hCAFE,     32'hFFC, 5'd14, 3'b110)};

        reset = 1'b1;
        i0 = '0;
        i3 = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        chk_out("reset u0", y0, '0);
        chk_out("reset u3", y3, '0);
        chk_val("reset stall u0", {31'b0, stall0}, 32'd0);
        chk_val("reset stall u3", {31'b0, stall3}, 32'd0);

        for (int k = 0; k < 13; k++) begin
            i0 = v[k].i;
            sb.push_back(v[k].o);
            #1;
            chk_val($sformatf("ws0 v%0d stall", k), {31'b0, stall0}, 32'd0);
            @(posedge clk);
            #1;
            pop_cmp($sformatf("ws0 v%0d", k), y0);
        end
        i0 = '0;

        run3("ws3 sw", mk(32'h20, 32'h5A5A5A5A, 5'd0, 4'b0010), mko(32'h0, 32'h20, 5'd0, 3'b000), 3);
        run3("ws3 lw", mk(32'h20, 32'h0, 5'd3, 4'b1101), mko(32'h5A5A5A5A, 32'h20, 5'd3, 3'b110), 3);
        run3("ws3 misaligned", mk(32'h6, 32'h1, 5'd0, 4'b0010), mko(32'h0, 32'h6, 5'd0, 3'b001), 0);
        run3("ws3 add", mk(32'h5, 32'h0, 5'd7, 4'b1000), mko(32'h0, 32'h5, 5'd7, 3'b100), 0);

        i3 = mk(32'h20, 32'h99, 5'd0, 4'b0010);
        #1;
        chk_val("rst seq stall c1", {31'b0, stall3}, 32'd1);
        @(posedge clk);
        #1;
        chk_val("rst seq stall c2", {31'b0, stall3}, 32'd1);
        reset = 1'b1;
        #1;
        chk_val("rst seq stall drop", {31'b0, stall3}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        i3 = '0;
        #1;
        chk_out("rst seq outputs", y3, '0);
        chk_val("rst seq stall idle", {31'b0, stall3}, 32'd0);
        run3("rst seq lw", mk(32'h20, 32'h0, 5'd4, 4'b1101), mko(32'h5A5A5A5A, 32'h20, 5'd4, 3'b110), 3);

        if (sb.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard leftover: %0d entries, expected 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
